// File: rtl/cpu_ctrl_pkg.sv
// Shared control-sequencer definitions: opcodes, IR field positions, state encoding.
// Optional watchdog is enabled by defining LDST_WAIT_WATCHDOG_EN.
package cpu_ctrl_pkg;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 27;

   localparam logic [4:0] OP_LD  = 5'b00000;
   localparam logic [4:0] OP_LDI = 5'b00001;
   localparam logic [4:0] OP_ST  = 5'b00010;
   localparam logic [4:0] OP_ADD = 5'b00011;

   typedef enum logic [3:0] {
      ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
   } state_e;

   typedef enum logic [1:0] {
      OPC_LD, OPC_LDI, OPC_ST, OPC_NONE
   } op_class_e;

   function automatic op_class_e classify(input logic [4:0] opc);
      case (opc)
         OP_LD:   return OPC_LD;
         OP_LDI:  return OPC_LDI;
         OP_ST:   return OPC_ST;
         default: return OPC_NONE;
      endcase
   endfunction

endpackage

// File: rtl/ldst_wait_timer.sv
// RAM-wait watchdog counter; only built when LDST_WAIT_WATCHDOG_EN is defined.
`ifdef LDST_WAIT_WATCHDOG_EN
module ldst_wait_timer (
   input  logic clock,
   input  logic clear,
   input  logic start,
   input  logic waiting,
   output logic expired
);

   logic [7:0] count;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear)
         count <= '0;
      else if (start)
         count <= '0;
      else if (waiting && count != 8'hFF)
         count <= count + 8'd1;
   end

   assign expired = (count == 8'hFF);

endmodule
`endif

// File: rtl/ldst_control_sequencer.sv
// Fetch / ld / ldi / st control-step sequencer driving DataPath strobes.
// Define LDST_WAIT_WATCHDOG_EN to add the RAM-wait watchdog and fault output.
module ldst_control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int         OPW    = 5,
   parameter logic [4:0] ADD_OP = OP_ADD
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        run,
   input  logic [31:0] ir,
   input  logic        mem_ready,
   output logic        PCout,
   output logic        Zlowout,
   output logic        MDRout,
   output logic        BAout,
   output logic        Cout,
   output logic        MARin,
   output logic        PCin,
   output logic        MDRin,
   output logic        IRin,
   output logic        Yin,
   output logic        ZLowIn,
   output logic        IncPC,
   output logic        Read,
   output logic        Write,
   output logic        Gra,
   output logic        Grb,
   output logic        Rin,
   output logic        Rout,
   output logic [4:0]  alu_op,
   output logic        busy,
   output logic        done,
   output logic        illegal,
   output logic        fault
);

   state_e    state, state_nxt;
   op_class_e op_q, op_nxt, op_dec;
   logic      first_q;
   logic      illegal_q;
   logic      nxt_wait;
   logic      entry;
   logic      tmo;
   logic [OPW-1:0] opcode;
   logic      unused_ir;

   assign opcode    = ir[OPC_MSB -: OPW];
   assign op_dec    = classify(opcode);
   assign unused_ir = ^ir[OPC_LSB-1:0];

   // A wait state is one that holds until mem_ready; entry marks its first cycle.
   assign nxt_wait = (state_nxt == ST_T1) ||
                     (state_nxt == ST_T6 && op_nxt == OPC_LD) ||
                     (state_nxt == ST_T7 && op_nxt == OPC_ST);
   assign entry    = nxt_wait && (state_nxt != state);

`ifdef LDST_WAIT_WATCHDOG_EN
   logic in_wait;
   logic expired;
   logic fault_q;

   assign in_wait = (state == ST_T1) ||
                    (state == ST_T6 && op_q == OPC_LD) ||
                    (state == ST_T7 && op_q == OPC_ST);

   ldst_wait_timer u_wait_timer (
      .clock   (clock),
      .clear   (clear),
      .start   (entry),
      .waiting (in_wait && !mem_ready),
      .expired (expired)
   );

   assign tmo = in_wait && !mem_ready && expired;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear)
         fault_q <= 1'b0;
      else if (tmo)
         fault_q <= 1'b1;
   end

   assign fault = fault_q;
`else
   assign tmo   = 1'b0;
   assign fault = 1'b0;
`endif

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state     <= ST_IDLE;
         op_q      <= OPC_LD;
         first_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         op_q    <= op_nxt;
         first_q <= entry;
         if (state == ST_T3 && op_dec == OPC_NONE)
            illegal_q <= 1'b1;
      end
   end

   assign illegal = illegal_q;

   always_comb begin
      state_nxt = state;
      op_nxt    = op_q;
      case (state)
         ST_IDLE: if (run) state_nxt = ST_T0;
         ST_T0:   state_nxt = ST_T1;
         ST_T1:   if (tmo) state_nxt = ST_HALT;
                  else if (mem_ready) state_nxt = ST_T2;
         ST_T2:   state_nxt = ST_T3;
         ST_T3: begin
            op_nxt    = op_dec;
            state_nxt = (op_dec == OPC_NONE) ? ST_HALT : ST_T4;
         end
         ST_T4:   state_nxt = ST_T5;
         ST_T5:   if (op_q == OPC_LDI) state_nxt = run ? ST_T0 : ST_IDLE;
                  else state_nxt = ST_T6;
         ST_T6:   if (op_q == OPC_ST) state_nxt = ST_T7;
                  else if (tmo) state_nxt = ST_HALT;
                  else if (mem_ready) state_nxt = ST_T7;
         ST_T7:   if (tmo) state_nxt = ST_HALT;
                  else if (op_q == OPC_LD || mem_ready) state_nxt = run ? ST_T0 : ST_IDLE;
         ST_HALT: state_nxt = ST_HALT;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Strobes follow the registered state; MDRin and the st completion track mem_ready.
   always_comb begin
      PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; BAout = 1'b0; Cout = 1'b0;
      MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
      ZLowIn = 1'b0; IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
      Gra = 1'b0; Grb = 1'b0; Rin = 1'b0; Rout = 1'b0;
      alu_op = 5'b00000;
      done   = 1'b0;
      busy   = (state != ST_IDLE) && (state != ST_HALT);
      case (state)
         ST_T0: begin
            PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
         end
         ST_T1: begin
            Zlowout = 1'b1; PCin = first_q; Read = !tmo; MDRin = mem_ready;
         end
         ST_T2: begin
            MDRout = 1'b1; IRin = 1'b1;
         end
         ST_T3: if (op_dec != OPC_NONE) begin
            Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
         end
         ST_T4: begin
            Cout = 1'b1; alu_op = ADD_OP; ZLowIn = 1'b1;
         end
         ST_T5: begin
            Zlowout = 1'b1;
            if (op_q == OPC_LDI) begin
               Gra = 1'b1; Rin = 1'b1; done = 1'b1;
            end else
               MARin = 1'b1;
         end
         ST_T6: if (op_q == OPC_ST) begin
            Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
         end else begin
            Read = !tmo; MDRin = mem_ready;
         end
         ST_T7: if (op_q == OPC_ST) begin
            Write = !tmo; done = mem_ready;
         end else begin
            MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ldst_control_sequencer.sv
// Scoreboard bench: directed per-cycle vectors queued by the driver, checked by a monitor.
module tb_ldst_control_sequencer;

   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic        run = 1'b0;
   logic [31:0] ir = 32'h0;
   logic        mem_ready = 1'b0;
   logic PCout, Zlowout, MDRout, BAout, Cout, MARin, PCin, MDRin, IRin, Yin;
   logic ZLowIn, IncPC, Read, Write, Gra, Grb, Rin, Rout, busy, done, illegal, fault;
   logic [4:0] alu_op;

   ldst_control_sequencer dut (
      .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
      .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .BAout(BAout), .Cout(Cout),
      .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .ZLowIn(ZLowIn), .IncPC(IncPC), .Read(Read), .Write(Write),
      .Gra(Gra), .Grb(Grb), .Rin(Rin), .Rout(Rout), .alu_op(alu_op),
      .busy(busy), .done(done), .illegal(illegal), .fault(fault)
   );

   always #5 clock = ~clock;

   localparam logic [26:0] PCOUT = 27'd1 << 26, ZLOWOUT = 27'd1 << 25, MDROUT = 27'd1 << 24;
   localparam logic [26:0] BAOUT = 27'd1 << 23, COUT = 27'd1 << 22, MARIN = 27'd1 << 21;
   localparam logic [26:0] PCIN = 27'd1 << 20, MDRIN = 27'd1 << 19, IRIN = 27'd1 << 18;
   localparam logic [26:0] YIN = 27'd1 << 17, ZLOWIN = 27'd1 << 16, INCPC = 27'd1 << 15;
   localparam logic [26:0] READ = 27'd1 << 14, WRITE = 27'd1 << 13, GRA = 27'd1 << 12;
   localparam logic [26:0] GRB = 27'd1 << 11, RIN = 27'd1 << 10, ROUT = 27'd1 << 9;
   localparam logic [26:0] BUSY = 27'd1 << 8, DONE = 27'd1 << 7, ILL = 27'd1 << 6;
   localparam logic [26:0] ADDOP = 27'd3;

   localparam logic [26:0] F0  = BUSY | PCOUT | MARIN | INCPC | ZLOWIN;
   localparam logic [26:0] F1  = BUSY | ZLOWOUT | PCIN | READ | MDRIN;
   localparam logic [26:0] F2  = BUSY | MDROUT | IRIN;
   localparam logic [26:0] D3  = BUSY | GRB | BAOUT | YIN;
   localparam logic [26:0] E4  = BUSY | COUT | ZLOWIN | ADDOP;
   localparam logic [26:0] L5  = BUSY | ZLOWOUT | GRA | RIN | DONE;
   localparam logic [26:0] M5  = BUSY | ZLOWOUT | MARIN;
   localparam logic [26:0] LD6 = BUSY | READ | MDRIN;
   localparam logic [26:0] LD7 = BUSY | MDROUT | GRA | RIN | DONE;
   localparam logic [26:0] ST6 = BUSY | GRA | ROUT | MDRIN;

   localparam logic [31:0] I_LDI = 32'h09800012;
   localparam logic [31:0] I_LD  = 32'h01000005;
   localparam logic [31:0] I_ST  = 32'h1200001F;
   localparam logic [31:0] I_BAD = 32'hF8000000;

   logic [26:0] act;
   assign act = {PCout, Zlowout, MDRout, BAout, Cout, MARin, PCin, MDRin, IRin, Yin,
                 ZLowIn, IncPC, Read, Write, Gra, Grb, Rin, Rout, busy, done, illegal,
                 fault, alu_op};

   typedef struct {
      logic [26:0] e;
      int          id;
   } exp_t;

   exp_t sb[$];
   int   step_id = 0;
   int   checks  = 0;
   int   errors  = 0;
   int   nwait   = 0;

   task automatic step(input logic c, input logic r, input logic [31:0] i,
                       input logic m, input logic [26:0] e);
      exp_t x;
      @(posedge clock);
      #1;
      clear = c; run = r; ir = i; mem_ready = m;
      x.e  = e;
      x.id = step_id;
      sb.push_back(x);
      step_id++;
   endtask

   always @(negedge clock) begin
      exp_t x;
      if (sb.size() != 0) begin
         x = sb.pop_front();
         checks++;
         if (act !== x.e) begin
            errors++;
            $display("FAIL step%0d outputs got=%h want=%h", x.id, act, x.e);
         end
      end
   end

   initial begin
      // reset and idle
      step(0, 0, 32'h0, 0, 27'd0);
      #1;
      checks++;
      if (act !== 27'd0 || illegal !== 1'b0 || fault !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset state got=%h", act);
      end
      step(0, 1, 32'h0, 1, 27'd0);
      // ldi, run dropped mid-instruction
      step(1, 1, I_LDI, 1, 27'd0);
      step(1, 1, I_LDI, 1, F0);
      step(1, 0, I_LDI, 1, F1);
      step(1, 0, I_LDI, 1, F2);
      step(1, 0, I_LDI, 1, D3);
      step(1, 0, I_LDI, 1, E4);
      step(1, 0, I_LDI, 1, L5);
      step(1, 0, I_LDI, 1, 27'd0);
      // ld chained straight into st
      step(1, 1, I_LD, 1, 27'd0);
      step(1, 1, I_LD, 1, F0);
      step(1, 1, I_LD, 1, F1);
      step(1, 1, I_LD, 1, F2);
      step(1, 1, I_LD, 1, D3);
      step(1, 1, I_LD, 1, E4);
      step(1, 1, I_LD, 1, M5);
      step(1, 1, I_LD, 1, LD6);
      step(1, 1, I_LD, 1, LD7);
      step(1, 1, I_LD, 0, F0);
      step(1, 1, I_LD, 1, F1);
      step(1, 1, I_ST, 0, F2);
      step(1, 1, I_ST, 0, D3);
      step(1, 1, I_ST, 0, E4);
      step(1, 1, I_ST, 0, M5);
      step(1, 1, I_ST, 0, ST6);
      step(1, 1, I_ST, 0, BUSY | WRITE);
      step(1, 1, I_ST, 0, BUSY | WRITE);
      step(1, 1, I_ST, 0, BUSY | WRITE);
      step(1, 0, I_ST, 1, BUSY | WRITE | DONE);
      step(1, 0, I_ST, 1, 27'd0);
      // fetch with two RAM wait cycles
      step(1, 1, I_LDI, 1, 27'd0);
      step(1, 1, I_LDI, 0, F0);
      step(1, 1, I_LDI, 0, BUSY | ZLOWOUT | PCIN | READ);
      step(1, 1, I_LDI, 0, BUSY | ZLOWOUT | READ);
      step(1, 1, I_LDI, 1, BUSY | ZLOWOUT | READ | MDRIN);
      step(1, 1, I_LDI, 1, F2);
      step(1, 1, I_LDI, 1, D3);
      step(1, 1, I_LDI, 1, E4);
      step(1, 0, I_LDI, 1, L5);
      step(1, 0, I_LDI, 1, 27'd0);
      // ld aborted by clear while waiting in T6
      step(1, 1, I_LD, 1, 27'd0);
      step(1, 1, I_LD, 1, F0);
      step(1, 1, I_LD, 1, F1);
      step(1, 1, I_LD, 1, F2);
      step(1, 1, I_LD, 1, D3);
      step(1, 1, I_LD, 1, E4);
      step(1, 1, I_LD, 0, M5);
      step(1, 1, I_LD, 0, BUSY | READ);
      step(0, 1, I_LD, 0, 27'd0);
      step(1, 1, I_LD, 1, 27'd0);
      // illegal opcode halts until clear
      step(1, 1, I_BAD, 1, F0);
      step(1, 1, I_BAD, 1, F1);
      step(1, 1, I_BAD, 1, F2);
      step(1, 1, I_BAD, 1, BUSY);
      step(1, 1, I_BAD, 1, ILL);
      step(1, 1, I_BAD, 1, ILL);
      step(1, 1, I_LDI, 1, ILL);
      step(0, 1, I_LDI, 1, 27'd0);
      step(1, 0, I_LDI, 1, 27'd0);
      @(negedge clock);
      @(negedge clock);
      // fetch wait with mem_ready stuck low
      @(posedge clock);
      #1;
      run = 1'b1; ir = I_LDI; mem_ready = 1'b0;
      nwait = 0;
      while (fault !== 1'b1 && nwait < 400) begin
         @(posedge clock);
         #1;
         nwait++;
      end
      checks++;
`ifdef LDST_WAIT_WATCHDOG_EN
      if (fault !== 1'b1 || Read !== 1'b0 || busy !== 1'b0 || nwait < 255 || nwait > 260) begin
         errors++;
         $display("FAIL expired wait fault=%b Read=%b busy=%b cycles=%0d", fault, Read, busy, nwait);
      end
`else
      if (fault !== 1'b0 || Read !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL endless wait fault=%b Read=%b busy=%b", fault, Read, busy);
      end
`endif
      clear = 1'b0;
      run = 1'b0;
      @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
